// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry,
// hold, flush-to-bubble and a saturating count of entries discarded by flush.
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [7:0]        flush_cnt_o
);
  logic              r_h_v, r_s_v;
  logic [DATA_W-1:0] r_h_d, r_s_d;
  logic [1:0]        r_cnt;
  logic [7:0]        r_fcnt;
  logic              w_acc, w_drn, w_h_v, w_s_v;
  logic [DATA_W-1:0] w_h_d, w_s_d;
  logic [8:0]        w_fsum;

  // With a skid entry the only state term of in_ready is the S valid flop.
  assign in_ready = rst_n & ~hold_i & ~flush_i & ((SKID != 0) ? ~r_s_v : (~r_h_v | out_ready));
  assign w_acc    = in_valid & in_ready;
  assign w_drn    = r_h_v & out_ready;
  // An entry drained on the flush edge completed its transfer, so it is not counted as discarded.
  assign w_fsum   = {1'b0, r_fcnt} + 9'(r_h_v) + 9'(r_s_v) - 9'(w_drn);

  always_comb begin
    w_h_v = r_h_v;
    w_s_v = r_s_v;
    w_h_d = r_h_d;
    w_s_d = r_s_d;
    if (flush_i) begin
      w_h_v = 1'b0;
      w_s_v = 1'b0;
      w_h_d = BUBBLE_VAL;
    end else if (~r_h_v | w_drn) begin
      w_h_v = r_s_v | w_acc;
      w_h_d = r_s_v ? r_s_d : (w_acc ? in_data : BUBBLE_VAL);
      w_s_v = 1'b0;
    end else if (w_acc && SKID != 0) begin
      w_s_v = 1'b1;
      w_s_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_v  <= 1'b0;
      r_s_v  <= 1'b0;
      r_h_d  <= BUBBLE_VAL;
      r_s_d  <= BUBBLE_VAL;
      r_cnt  <= 2'd0;
      r_fcnt <= 8'd0;
    end else begin
      r_h_v  <= w_h_v;
      r_s_v  <= w_s_v;
      r_h_d  <= w_h_d;
      r_s_d  <= w_s_d;
      r_cnt  <= {w_h_v & w_s_v, w_h_v ^ w_s_v};
      r_fcnt <= flush_i ? (w_fsum[8] ? 8'hFF : w_fsum[7:0]) : r_fcnt;
    end
  end

  assign out_valid   = r_h_v;
  assign out_data    = r_h_d;
  assign count_o     = r_cnt;
  assign flush_cnt_o = r_fcnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a SKID=1 and a SKID=0 instance side by side and
// compares both against a FIFO-style reference model of the stage.
module tb_pipe_stage_reg;
  localparam logic [63:0] BUB1 = 64'hDEAD_BEEF_0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv[2], ir[2], ov[2], ord[2], hold[2], fl[2];
  logic [63:0] id[2], od[2];
  logic [1:0]  cnt[2];
  logic [7:0]  fc[2];

  logic [63:0] m_e[2][2];
  int          m_n[2];
  int          m_fc[2];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .hold_i(hold[0]),
    .flush_i(fl[0]), .count_o(cnt[0]), .flush_cnt_o(fc[0]));

  pipe_stage_reg #(.DATA_W(64), .SKID(0), .BUBBLE_VAL(BUB1)) u_flat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .hold_i(hold[1]),
    .flush_i(fl[1]), .count_o(cnt[1]), .flush_cnt_o(fc[1]));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit exp_rdy(int k);
    return rst_n && !hold[k] && !fl[k] && (k == 0 ? m_n[k] < 2 : (m_n[k] == 0 || ord[k]));
  endfunction

  task automatic model(int k);
    bit d = m_n[k] > 0 && ord[k];
    bit a = iv[k] && exp_rdy(k);
    int t;
    if (!rst_n) return;
    if (fl[k]) begin
      t = m_fc[k] + m_n[k] - (d ? 1 : 0);
      m_fc[k] = t > 255 ? 255 : t;
      m_n[k] = 0;
    end else begin
      if (d) begin
        m_e[k][0] = m_e[k][1];
        m_n[k]--;
      end
      if (a) begin
        m_e[k][m_n[k]] = id[k];
        m_n[k]++;
      end
    end
  endtask

  task automatic check_out(int k);
    chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(m_n[k] > 0));
    chk($sformatf("out_data%0d", k), od[k], m_n[k] > 0 ? m_e[k][0] : (k == 0 ? 64'd0 : BUB1));
    chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(m_n[k]));
    chk($sformatf("flush_cnt%0d", k), 64'(fc[k]), 64'(m_fc[k]));
  endtask

  task automatic drv(int k, bit v, logic [63:0] d, bit r, bit h, bit f);
    iv[k] = v; id[k] = d; ord[k] = r; hold[k] = h; fl[k] = f;
  endtask

  task automatic rnd(int k);
    drv(k, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
        $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
  endtask

  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(exp_rdy(k)));
      model(k);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_out(k);
  endtask

  task automatic idle(int k);
    drv(k, 0, 64'd0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      m_n[k] = 0;
      m_fc[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_out(k);
      chk($sformatf("rst_in_ready%0d", k), 64'(ir[k]), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drv(0, 1, 64'(i), 1, 0, 0);
      tick();
    end
    drv(0, 0, 64'd0, 1, 0, 0);
    tick();
    drv(0, 1, 64'hA, 0, 0, 0); tick();
    drv(0, 1, 64'hB, 0, 0, 0); tick();
    drv(0, 1, 64'hC, 0, 0, 0); tick();
    chk("bp_ready_low", 64'(ir[0]), 64'd0);
    drv(0, 1, 64'hC, 1, 0, 0); tick();
    drv(0, 1, 64'hC, 1, 0, 0); tick();
    drv(0, 0, 64'd0, 1, 0, 0); tick(); tick();
    for (int i = 0; i < 128; i++) begin
      drv(0, 1, 64'h5, 0, 0, 0); tick();
      drv(0, 1, 64'h6, 0, 0, 0); tick();
      drv(0, 0, 64'd0, 0, 0, 1); tick();
    end
    chk("flush_sat", 64'(fc[0]), 64'd255);
    drv(0, 1, 64'h7, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 64'h9, 1, 1, 0);
      tick();
    end
    chk("hold_drained", od[0], 64'd0);
    idle(0);
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 64'h100 + 64'(i), 1, 0, 0);
      tick();
    end
    drv(1, 1, 64'h200, 0, 0, 0); tick(); tick();
    drv(1, 0, 64'd0, 1, 0, 1); tick();
    chk("flush_drain_cnt", 64'(fc[1]), 64'd0);
    drv(1, 1, 64'h300, 0, 0, 0); tick();
    drv(1, 0, 64'd0, 0, 0, 1); tick();
    chk("flush_one_cnt", 64'(fc[1]), 64'd1);
    idle(1);
    drv(0, 1, 64'h11, 0, 0, 0); tick();
    drv(0, 1, 64'h22, 0, 0, 0); tick();
    chk("pre_reset_cnt", 64'(cnt[0]), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0;
      m_fc[k] = 0;
      check_out(k);
      chk($sformatf("arst_in_ready%0d", k), 64'(ir[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(0);
    tick(); tick();
    for (int i = 0; i < 3000; i++) begin
      rnd(0);
      rnd(1);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the CPU datapath, generalising the fixed IF/ID latch into a reusable stage between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload under a valid/ready handshake, with an optional two-entry skid buffer that breaks the ready path. It supports a hold (write-disable) input and a synchronous flush that inserts a configurable bubble value. It also counts valid entries discarded by flushes.

## Interface
- DATA_W, 64, payload width (e.g. PC+4 concatenated with the instruction word)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0 (NOP encoding)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_data  output  DATA_W  head payload; BUBBLE_VAL when out_valid=0
- hold_i  input  1  write-disable: blocks acceptance only
- flush_i  input  1  synchronous discard of all entries
- count_o  output  2  occupancy: 0..1 if SKID=0, 0..2 if SKID=1
- flush_cnt_o  output  8  saturating count of valid entries discarded by flush

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready is forced 0 while rst_n=0, hold_i=1 or flush_i=1. These gates are combinational.
- SKID=1:
  - State: head entry H (drives out_*) and skid entry S.
  - in_ready = !S.valid & !hold_i & !flush_i. The only state term is a register.
  - H empty and accept: H <= in.
  - H full, drain, S empty: H <= in if accept, else H empties.
  - H full, no drain, accept: S <= in. Order is preserved.
  - H and S full, drain: H <= S and S empties. No accept is possible because in_ready=0.
- SKID=0:
  - Single entry H.
  - in_ready = (!H.valid | out_ready) & !hold_i & !flush_i.
  - Accept with drain in the same cycle replaces H.
- hold_i=1:
  - No acceptance.
  - The downstream drain continues. In SKID=1 mode, S moves into H when H drains.
- flush_i=1 on an edge:
  - H and S are invalidated, and out_data becomes BUBBLE_VAL next cycle.
  - Flush has priority over the drain, the skid move and acceptance.
  - flush_cnt_o += (number of valid entries at that edge), saturating at 255 (e.g. 254 + 2 -> 255).
  - A drain occurring in the same cycle as a flush is still a completed transfer from the downstream's point of view. The drained entry is not counted as discarded: flush_cnt_o adds occupancy minus 1 in that case.
- count_o always equals H.valid + S.valid.
- Payload registers update only on a write; a stalled entry holds its value bit-exactly.

## Timing
- Reset (async assert, sync release by the system):
  - out_valid=0, out_data=BUBBLE_VAL, count_o=0, flush_cnt_o=0, in_ready=0.
  - S and H cleared.
  - Reset mid-transfer drops all entries and is not counted in flush_cnt_o.
- First edge after release: in_ready=1 unless hold_i or flush_i is asserted.
- Latency: accept at edge N gives out_valid=1 with that payload after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle with out_ready held at 1 (both modes).
- SKID=1 backpressure: after out_ready falls, the stage absorbs at most one further beat. in_ready drops in the cycle after S fills.
- Recovery after out_ready rises with H and S full: S moves to H at the next edge, and in_ready=1 in the following cycle.
- All outputs except in_ready are registered. in_ready is combinational only in its hold_i, flush_i and (SKID=0) out_ready terms.

## Test plan
- Streaming: SKID=1, out_ready=1, 8 beats 0x1..0x8 back-to-back -> out_data 0x1..0x8 one cycle later, no gaps, count_o=1 steady.
- Backpressure: SKID=1, out_ready=0 after beat 0xA accepted, send 0xB, 0xC. Expected:
  - 0xB lands in S and in_ready drops.
  - 0xC is held upstream.
  - Releasing out_ready gives 0xA, 0xB, 0xC in order.
  - count_o sequence is 1, 2, 2, 1, ...
- Flush with full buffer: H=0x5, S=0x6, flush_i pulse with out_ready=0. Expected next cycle: out_valid=0, out_data=BUBBLE_VAL, count_o=0, flush_cnt_o=2. Repeat 128 times -> flush_cnt_o saturates at 255.
- Hold: hold_i=1 with in_valid=1 for 3 cycles -> in_ready=0, no capture. The existing H drains normally and out_data returns to BUBBLE_VAL.
- SKID=0 replace: H full, out_ready=1 and in_valid=1 each cycle -> in_ready=1 combinationally, continuous 1/cycle. With out_ready=0 -> in_ready=0 in the same cycle.
- Async reset mid-stream: assert rst_n low between edges with count_o=2 -> outputs immediately reset values, flush_cnt_o stays 0.
